// File: rtl/vector_reg_bank.sv
// Multi-lane vector register bank: 2 read ports, 1 masked write port, busy scoreboard.
// Optional write-through forwarding to the read ports when VREG_BYPASS_EN is defined.
module vector_reg_bank #(
  parameter int LANES    = 4,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_enable,
  input  logic [LANES-1:0]        lane_mask,
  input  logic [ADDR_W-1:0]       rd,
  input  logic [LANES*DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0]       rs1,
  input  logic [ADDR_W-1:0]       rs2,
  output logic [LANES*DATA_W-1:0] ro1,
  output logic [LANES*DATA_W-1:0] ro2,
  input  logic                    reserve_en,
  input  logic [ADDR_W-1:0]       reserve_reg,
  output logic                    busy1,
  output logic                    busy2,
  output logic [NUM_REGS-1:0]     busy_vec
);

  logic [LANES*DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]     busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      if (write_enable) begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_mask[i]) regs[rd][i*DATA_W +: DATA_W] <= write_data[i*DATA_W +: DATA_W];
        end
      end
      // A reservation on the same edge as the write means a newer producer is in flight.
      for (int r = 0; r < NUM_REGS; r++) begin
        if (reserve_en && reserve_reg == ADDR_W'(r))       busy[r] <= 1'b1;
        else if (write_enable && rd == ADDR_W'(r))         busy[r] <= 1'b0;
      end
    end
  end

  assign busy_vec = busy;

  always_comb begin
    ro1   = regs[rs1];
    ro2   = regs[rs2];
    busy1 = busy[rs1];
    busy2 = busy[rs2];
`ifdef VREG_BYPASS_EN
    if (write_enable && rd == rs1) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_mask[i]) ro1[i*DATA_W +: DATA_W] = write_data[i*DATA_W +: DATA_W];
      end
      busy1 = reserve_en && reserve_reg == rs1;
    end
    if (write_enable && rd == rs2) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_mask[i]) ro2[i*DATA_W +: DATA_W] = write_data[i*DATA_W +: DATA_W];
      end
      busy2 = reserve_en && reserve_reg == rs2;
    end
`endif
  end

endmodule

// File: tb/tb_vector_reg_bank.sv
// Randomised self-checking bench for vector_reg_bank against an array-based model.
module tb_vector_reg_bank;
  localparam int LANES = 4, DATA_W = 32, NUM_REGS = 8, ADDR_W = 3;
  localparam int W = LANES * DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, write_enable, reserve_en;
  logic [LANES-1:0]    lane_mask;
  logic [ADDR_W-1:0]   rd, rs1, rs2, reserve_reg;
  logic [W-1:0]        write_data, ro1, ro2;
  logic                busy1, busy2;
  logic [NUM_REGS-1:0] busy_vec;

  vector_reg_bank #(.LANES(LANES), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .lane_mask(lane_mask), .rd(rd),
    .write_data(write_data), .rs1(rs1), .rs2(rs2), .ro1(ro1), .ro2(ro2),
    .reserve_en(reserve_en), .reserve_reg(reserve_reg), .busy1(busy1), .busy2(busy2),
    .busy_vec(busy_vec));

  logic [DATA_W-1:0] mem [NUM_REGS][LANES];
  bit                mbusy [NUM_REGS];
  int vectors = 0, errors = 0;

  function automatic logic [W-1:0] exp_read(input logic [ADDR_W-1:0] a);
    logic [W-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      v[i*DATA_W +: DATA_W] = mem[a][i];
`ifdef VREG_BYPASS_EN
      if (write_enable && rd == a && lane_mask[i]) v[i*DATA_W +: DATA_W] = write_data[i*DATA_W +: DATA_W];
`endif
    end
    return v;
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = mbusy[a];
`ifdef VREG_BYPASS_EN
    if (write_enable && rd == a) b = reserve_en && reserve_reg == a;
`endif
    return b;
  endfunction

  function automatic logic [NUM_REGS-1:0] exp_busy_vec();
    logic [NUM_REGS-1:0] v;
    for (int r = 0; r < NUM_REGS; r++) v[r] = mbusy[r];
    return v;
  endfunction

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mbusy[r] = 1'b0;
        for (int i = 0; i < LANES; i++) mem[r][i] = '0;
      end
    end else begin
      if (write_enable) begin
        for (int i = 0; i < LANES; i++)
          if (lane_mask[i]) mem[rd][i] = write_data[i*DATA_W +: DATA_W];
        mbusy[rd] = 1'b0;
      end
      if (reserve_en) mbusy[reserve_reg] = 1'b1;
    end
  endtask

  // Inputs are set just after a falling edge; check mid-cycle, then advance one clock.
  task automatic cycle();
    #1;
    cmp("ro1", ro1, exp_read(rs1));
    cmp("ro2", ro2, exp_read(rs2));
    cmp("busy1", W'(busy1), W'(exp_busy(rs1)));
    cmp("busy2", W'(busy2), W'(exp_busy(rs2)));
    cmp("busy_vec", W'(busy_vec), W'(exp_busy_vec()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b1; write_enable = 1'b0; reserve_en = 1'b0; lane_mask = '0;
  endtask

  initial begin
    rst = 1'b0; write_enable = 1'b0; reserve_en = 1'b0; lane_mask = '0; rd = '0;
    write_data = '0; rs1 = '0; rs2 = '0; reserve_reg = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      mbusy[r] = 1'b0;
      for (int i = 0; i < LANES; i++) mem[r][i] = 'x;
    end
    @(negedge clk);
    @(posedge clk); model_edge(); @(negedge clk);
    @(posedge clk); model_edge(); @(negedge clk);
    idle();

    for (int r = 0; r < NUM_REGS; r++) begin
      rs1 = ADDR_W'(r); rs2 = ADDR_W'(r);
      #1;
      cmp("lit_reset_ro1", ro1, '0);
      cmp("lit_reset_ro2", ro2, '0);
      cycle();
    end
    #1 cmp("lit_reset_busy_vec", W'(busy_vec), W'(8'h00));

    write_enable = 1'b1; rd = 3'd0; lane_mask = 4'hF;
    write_data = {32'd4, 32'd3, 32'd2, 32'd1};
    cycle();
    rd = 3'd1; write_data = {32'd9, 32'd7, 32'd587, 32'd54};
    cycle();
    idle(); rs1 = 3'd0; rs2 = 3'd1;
    #1;
    cmp("lit_ro1_reg0", ro1, {32'd4, 32'd3, 32'd2, 32'd1});
    cmp("lit_ro2_reg1", ro2, {32'd9, 32'd7, 32'd587, 32'd54});
    cycle();

    write_enable = 1'b1; rd = 3'd0; lane_mask = 4'b0101; write_data = {4{32'hFFFF_FFFF}};
    cycle();
    idle(); rs1 = 3'd0;
    #1 cmp("lit_masked_write", ro1, {32'd4, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF});
    cycle();

    reserve_en = 1'b1; reserve_reg = 3'd3;
    cycle();
    idle(); rs1 = 3'd3;
    #1;
    cmp("lit_busy1_set", W'(busy1), W'(1'b1));
    cmp("lit_busy_vec_08", W'(busy_vec), W'(8'h08));
    write_enable = 1'b1; rd = 3'd3; lane_mask = 4'hF; write_data = {4{32'h1234_5678}};
    cycle();
    idle();
    #1 cmp("lit_busy1_cleared", W'(busy1), W'(1'b0));
    cycle();

    reserve_en = 1'b1; reserve_reg = 3'd5;
    write_enable = 1'b1; rd = 3'd5; lane_mask = 4'hF; write_data = {4{32'hA5}};
    cycle();
    idle(); rs1 = 3'd5;
    #1;
    cmp("lit_reserve_wins", W'(busy_vec[5]), W'(1'b1));
    cmp("lit_reg5_a5", ro1, {4{32'hA5}});
    cycle();

    reserve_en = 1'b1; reserve_reg = 3'd2;
    cycle();
    idle(); rst = 1'b0; write_enable = 1'b1; rd = 3'd2; lane_mask = 4'hF; write_data = {4{32'hDEAD}};
    cycle();
    idle(); rs1 = 3'd2;
    #1;
    cmp("lit_midreset_busy", W'(busy_vec), W'(8'h00));
    cmp("lit_midreset_reg2", ro1, '0);
    cycle();

    write_enable = 1'b1; rd = 3'd6; rs1 = 3'd6; lane_mask = 4'hF; write_data = {4{32'd11}};
`ifdef VREG_BYPASS_EN
    #1 cmp("lit_bypass_before", ro1, {4{32'd11}});
`else
    #1 cmp("lit_nobypass_before", ro1, '0);
`endif
    cycle();
    idle();
    #1 cmp("lit_after_edge", ro1, {4{32'd11}});
    cycle();

    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 59) != 0);
      write_enable = $urandom_range(0, 1);
      lane_mask    = LANES'($urandom);
      rd           = ADDR_W'($urandom);
      for (int i = 0; i < LANES; i++) write_data[i*DATA_W +: DATA_W] = $urandom;
      reserve_en   = ($urandom_range(0, 2) == 0);
      reserve_reg  = ($urandom_range(0, 3) == 0) ? rd : ADDR_W'($urandom);
      rs1          = ($urandom_range(0, 2) == 0) ? rd : ADDR_W'($urandom);
      rs2          = ($urandom_range(0, 3) == 0) ? rs1 : ADDR_W'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
